// File: rtl/clkdiv_sequencer.sv
// Reset/phase-slip sequencer for a clock divider: holds RESETN, waits for settling, then issues CALIB slip pulses.
// Optional `CLKDIV_SEQ_SLIPCNT_EN adds the slip_total counter port.
module clkdiv_sequencer #(
  parameter int unsigned RST_HOLD  = 16,
  parameter int unsigned SETTLE    = 64,
  parameter int unsigned CALIB_HI  = 2,
  parameter int unsigned CALIB_GAP = 8
) (
  input  logic       hclkin,
  input  logic       reset,
  input  logic       restart,
  input  logic       slip_req,
  input  logic [2:0] slip_num,
  output logic       slip_ack,
  output logic       div_resetn,
  output logic       div_calib,
  output logic       ready,
  output logic       busy
`ifdef CLKDIV_SEQ_SLIPCNT_EN
  ,
  output logic [7:0] slip_total
`endif
);

  typedef enum logic [2:0] {
    ST_HOLD,
    ST_SETTLE,
    ST_READY,
    ST_CAL_HI,
    ST_CAL_GAP
  } state_t;

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic [2:0] rem, rem_nx;
  logic       ack_nx;
  logic [7:0] hold_cnt;

  // HOLD is entered with cnt=0 (reset or restart); 0 stands for a full RST_HOLD count.
  assign hold_cnt = (cnt == 8'd0) ? 8'(RST_HOLD) : cnt;

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    rem_nx   = rem;
    ack_nx   = 1'b0;
    if (restart) begin
      state_nx = ST_HOLD;
      cnt_nx   = 8'd0;
      rem_nx   = 3'd0;
    end else begin
      case (state)
        ST_HOLD: begin
          if (hold_cnt == 8'd1) begin
            state_nx = ST_SETTLE;
            cnt_nx   = 8'(SETTLE);
          end else begin
            cnt_nx = hold_cnt - 8'd1;
          end
        end
        ST_SETTLE: begin
          if (cnt <= 8'd1) begin
            state_nx = ST_READY;
            cnt_nx   = 8'd0;
          end else begin
            cnt_nx = cnt - 8'd1;
          end
        end
        ST_READY: begin
          if (slip_req && !slip_ack) begin
            rem_nx = slip_num;
            if (slip_num == 3'd0) begin
              ack_nx = 1'b1;
            end else begin
              state_nx = ST_CAL_HI;
              cnt_nx   = 8'(CALIB_HI);
            end
          end
        end
        ST_CAL_HI: begin
          if (cnt <= 8'd1) begin
            state_nx = ST_CAL_GAP;
            cnt_nx   = 8'(CALIB_GAP);
            rem_nx   = rem - 3'd1;
          end else begin
            cnt_nx = cnt - 8'd1;
          end
        end
        ST_CAL_GAP: begin
          if (cnt > 8'd1) begin
            cnt_nx = cnt - 8'd1;
          end else if (rem != 3'd0) begin
            state_nx = ST_CAL_HI;
            cnt_nx   = 8'(CALIB_HI);
          end else begin
            state_nx = ST_READY;
            cnt_nx   = 8'd0;
            ack_nx   = 1'b1;
          end
        end
        default: begin
          state_nx = ST_HOLD;
          cnt_nx   = 8'd0;
          rem_nx   = 3'd0;
        end
      endcase
    end
  end

  // Outputs are decoded from the next state so they change on the same edge as the state.
  always_ff @(posedge hclkin or posedge reset) begin
    if (reset) begin
      state      <= ST_HOLD;
      cnt        <= 8'd0;
      rem        <= 3'd0;
      div_resetn <= 1'b0;
      div_calib  <= 1'b0;
      ready      <= 1'b0;
      busy       <= 1'b1;
      slip_ack   <= 1'b0;
    end else begin
      state      <= state_nx;
      cnt        <= cnt_nx;
      rem        <= rem_nx;
      div_resetn <= (state_nx != ST_HOLD);
      div_calib  <= (state_nx == ST_CAL_HI);
      ready      <= (state_nx == ST_READY);
      busy       <= (state_nx != ST_READY);
      slip_ack   <= ack_nx;
    end
  end

`ifdef CLKDIV_SEQ_SLIPCNT_EN
  // Counts div_calib rising edges; restart deliberately leaves it alone.
  always_ff @(posedge hclkin or posedge reset) begin
    if (reset) begin
      slip_total <= 8'd0;
    end else if ((state_nx == ST_CAL_HI) && !div_calib) begin
      slip_total <= slip_total + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_clkdiv_sequencer.sv
// Directed self-checking bench for clkdiv_sequencer with default parameters.
// Define CLKDIV_SEQ_SLIPCNT_EN to also exercise the slip_total counter.
module tb_clkdiv_sequencer;

  logic       hclkin = 1'b0;
  logic       reset;
  logic       restart;
  logic       slip_req;
  logic [2:0] slip_num;
  logic       slip_ack;
  logic       div_resetn;
  logic       div_calib;
  logic       ready;
  logic       busy;
`ifdef CLKDIV_SEQ_SLIPCNT_EN
  logic [7:0] slip_total;
`endif

  int errors = 0;
  int checks = 0;

  clkdiv_sequencer dut (
    .hclkin     (hclkin),
    .reset      (reset),
    .restart    (restart),
    .slip_req   (slip_req),
    .slip_num   (slip_num),
    .slip_ack   (slip_ack),
    .div_resetn (div_resetn),
    .div_calib  (div_calib),
    .ready      (ready),
    .busy       (busy)
`ifdef CLKDIV_SEQ_SLIPCNT_EN
    ,
    .slip_total (slip_total)
`endif
  );

  always #5 hclkin = ~hclkin;

  task automatic step(input int n);
    repeat (n) @(negedge hclkin);
  endtask

  task automatic applyStimulus(input logic rst_v, input logic rs_v, input logic req_v,
                               input logic [2:0] num_v);
    reset    = rst_v;
    restart  = rs_v;
    slip_req = req_v;
    slip_num = num_v;
  endtask

  task automatic checkOutput(input string tag, input logic [7:0] observed,
                             input logic [7:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

`ifdef CLKDIV_SEQ_SLIPCNT_EN
  // Request n slips from READY and wait (bounded) for the acknowledge.
  task automatic runSlip(input logic [2:0] n);
    int got;
    got = 0;
    applyStimulus(1'b0, 1'b0, 1'b1, n);
    for (int c = 0; c < 200 && got == 0; c++) begin
      step(1);
      if (slip_ack === 1'b1) got = 1;
    end
    applyStimulus(1'b0, 1'b0, 1'b0, n);
    checkOutput("slip_ack_seen", 8'(got), 8'd1);
    step(1);
  endtask
`endif

  initial begin
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    step(2);
    checkOutput("rst_resetn", div_resetn, 1'b0);
    checkOutput("rst_calib", div_calib, 1'b0);
    checkOutput("rst_ready", ready, 1'b0);
    checkOutput("rst_busy", busy, 1'b1);
    checkOutput("rst_ack", slip_ack, 1'b0);

    // Power-up: resetn high after edge 16, ready after edge 80.
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    for (int k = 1; k <= 80; k++) begin
      step(1);
      checkOutput($sformatf("pu_resetn_%0d", k), div_resetn, (k >= 16) ? 8'd1 : 8'd0);
      checkOutput($sformatf("pu_ready_%0d", k), ready, (k >= 80) ? 8'd1 : 8'd0);
      checkOutput($sformatf("pu_busy_%0d", k), busy, (k >= 80) ? 8'd0 : 8'd1);
      checkOutput($sformatf("pu_calib_%0d", k), div_calib, 8'd0);
    end

    // Three slips: 2 high, 8 low, repeated, 30 busy cycles then one ack.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3);
    for (int i = 0; i < 30; i++) begin
      step(1);
      checkOutput($sformatf("s3_calib_%0d", i), div_calib, ((i % 10) < 2) ? 8'd1 : 8'd0);
      checkOutput($sformatf("s3_ready_%0d", i), ready, 8'd0);
      checkOutput($sformatf("s3_busy_%0d", i), busy, 8'd1);
      checkOutput($sformatf("s3_ack_%0d", i), slip_ack, 8'd0);
      checkOutput($sformatf("s3_resetn_%0d", i), div_resetn, 8'd1);
    end
    step(1);
    checkOutput("s3_done_ready", ready, 1'b1);
    checkOutput("s3_done_ack", slip_ack, 1'b1);
    checkOutput("s3_done_calib", div_calib, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd3);
    step(1);
    checkOutput("s3_ack_drop", slip_ack, 1'b0);
    checkOutput("s3_ready_hold", ready, 1'b1);

    // Zero slips: immediate ack, no calib, ready stays high.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd0);
    step(1);
    checkOutput("s0_ack", slip_ack, 1'b1);
    checkOutput("s0_ready", ready, 1'b1);
    checkOutput("s0_calib", div_calib, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    for (int k = 0; k < 4; k++) begin
      step(1);
      checkOutput($sformatf("s0_ack_low_%0d", k), slip_ack, 8'd0);
      checkOutput($sformatf("s0_calib_low_%0d", k), div_calib, 8'd0);
      checkOutput($sformatf("s0_ready_hi_%0d", k), ready, 8'd1);
    end

    // Restart during the second cycle of the first CAL_HI pulse.
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd3);
    step(1);
    checkOutput("rs_calib_c1", div_calib, 1'b1);
    step(1);
    checkOutput("rs_calib_c2", div_calib, 1'b1);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    step(1);
    checkOutput("rs_calib", div_calib, 1'b0);
    checkOutput("rs_resetn", div_resetn, 1'b0);
    checkOutput("rs_ready", ready, 1'b0);
    checkOutput("rs_busy", busy, 1'b1);
    checkOutput("rs_ack", slip_ack, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    for (int k = 1; k <= 80; k++) begin
      step(1);
      checkOutput($sformatf("rs_resetn_%0d", k), div_resetn, (k >= 16) ? 8'd1 : 8'd0);
      checkOutput($sformatf("rs_ready_%0d", k), ready, (k >= 80) ? 8'd1 : 8'd0);
      checkOutput($sformatf("rs_ack_%0d", k), slip_ack, 8'd0);
      checkOutput($sformatf("rs_calib_%0d", k), div_calib, 8'd0);
    end

    // slip_req=1, slip_num=2 held from reset: ignored until READY.
    applyStimulus(1'b1, 1'b0, 1'b1, 3'd2);
    step(2);
    checkOutput("hr_rst_ready", ready, 1'b0);
    applyStimulus(1'b0, 1'b0, 1'b1, 3'd2);
    for (int k = 1; k <= 80; k++) begin
      step(1);
      checkOutput($sformatf("hr_calib_%0d", k), div_calib, 8'd0);
      checkOutput($sformatf("hr_ready_%0d", k), ready, (k >= 80) ? 8'd1 : 8'd0);
    end
    for (int i = 0; i < 20; i++) begin
      step(1);
      checkOutput($sformatf("hr_pcalib_%0d", i), div_calib, ((i % 10) < 2) ? 8'd1 : 8'd0);
      checkOutput($sformatf("hr_pready_%0d", i), ready, 8'd0);
      checkOutput($sformatf("hr_pack_%0d", i), slip_ack, 8'd0);
    end
    step(1);
    checkOutput("hr_ack", slip_ack, 1'b1);
    checkOutput("hr_ready", ready, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd2);
    for (int k = 0; k < 5; k++) begin
      step(1);
      checkOutput($sformatf("hr_post_ack_%0d", k), slip_ack, 8'd0);
      checkOutput($sformatf("hr_post_calib_%0d", k), div_calib, 8'd0);
      checkOutput($sformatf("hr_post_ready_%0d", k), ready, 8'd1);
      checkOutput($sformatf("hr_post_busy_%0d", k), busy, 8'd0);
    end

`ifdef CLKDIV_SEQ_SLIPCNT_EN
    applyStimulus(1'b1, 1'b0, 1'b0, 3'd0);
    step(2);
    checkOutput("tot_rst", slip_total, 8'd0);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    step(80);
    checkOutput("tot_ready", ready, 1'b1);
    runSlip(3'd3);
    runSlip(3'd3);
    checkOutput("tot_six", slip_total, 8'd6);
    applyStimulus(1'b0, 1'b1, 1'b0, 3'd0);
    step(1);
    applyStimulus(1'b0, 1'b0, 1'b0, 3'd0);
    step(80);
    checkOutput("tot_restart_ready", ready, 1'b1);
    checkOutput("tot_restart_keep", slip_total, 8'd6);
    for (int r = 0; r < 35; r++) runSlip(3'd7);
    checkOutput("tot_251", slip_total, 8'd251);
    runSlip(3'd5);
    checkOutput("tot_wrap", slip_total, 8'd0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clkdiv_sequencer.md
CLKDIV_SEQUENCER -- requirements
Module: clkdiv_sequencer

Interface
REQ-001 SHALL have parameter RST_HOLD, default 16: hclkin cycles div_resetn is held low; legal range 1..255.
REQ-002 SHALL have parameter SETTLE, default 64: hclkin cycles after div_resetn rises before ready; legal range 1..255.
REQ-003 SHALL have parameter CALIB_HI, default 2: width of each div_calib pulse in hclkin cycles; legal range 1..255.
REQ-004 SHALL have parameter CALIB_GAP, default 8: minimum div_calib-low cycles after each pulse; legal range 1..255.
REQ-005 SHALL have port hclkin, input, 1 bit: the single clock, i.e. the divider's fast input clock.
REQ-006 SHALL have port reset, input, 1 bit: asynchronous, active-high reset.
REQ-007 SHALL have port restart, input, 1 bit: request to re-run the divider reset sequence.
REQ-008 SHALL have port slip_req, input, 1 bit: level request for phase slips.
REQ-009 SHALL have port slip_num, input, 3 bits: number of slips requested; sampled on acceptance.
REQ-010 SHALL have port slip_ack, output, 1 bit: one-cycle pulse when a slip request completes.
REQ-011 SHALL have port div_resetn, output, 1 bit: drives the divider's RESETN input.
REQ-012 SHALL have port div_calib, output, 1 bit: drives the divider's CALIB input.
REQ-013 SHALL have port ready, output, 1 bit: divided clock is stable and phase is final.
REQ-014 SHALL have port busy, output, 1 bit: sequencer is not in READY.

Function
REQ-015 SHALL implement states HOLD, SETTLE, READY, CAL_HI and CAL_GAP with one shared 8-bit down-counter; all outputs SHALL be registered.
REQ-016 HOLD SHALL drive div_resetn=0 for RST_HOLD cycles, then go to SETTLE with div_resetn=1.
REQ-017 SETTLE SHALL last SETTLE cycles, then go to READY, where ready=1 and busy=0.
REQ-018 In READY, when slip_req=1 and slip_ack=0, the block SHALL latch slip_num into a remaining-slip counter.
REQ-019 On such acceptance with a nonzero count, the block SHALL enter CAL_HI with ready=0 and busy=1 on the next cycle.
REQ-020 On acceptance with slip_num=0, slip_ack SHALL pulse on the next cycle, the state SHALL stay READY, and no div_calib pulse SHALL occur.
REQ-021 CAL_HI SHALL drive div_calib=1 for exactly CALIB_HI cycles, decrement the remaining-slip counter, and enter CAL_GAP.
REQ-022 CAL_GAP SHALL drive div_calib=0 for CALIB_GAP cycles, then enter CAL_HI if remaining is nonzero.
REQ-023 Otherwise CAL_GAP SHALL enter READY, raise ready, and pulse slip_ack for exactly one cycle.
REQ-024 slip_req SHALL be ignored in HOLD, SETTLE, CAL_HI, CAL_GAP and in any cycle where slip_ack=1; the requester deasserts slip_req on ack.
REQ-025 restart=1 in any state SHALL take priority over slip_req.
REQ-026 On restart the block SHALL enter HOLD next cycle with div_resetn=0, div_calib=0, ready=0, busy=1 and the counters reloaded.
REQ-027 A pending slip request aborted by restart SHALL not be acknowledged.
REQ-028 restart asserted while in HOLD SHALL reload the RST_HOLD count.
REQ-029 div_calib and div_resetn=0 SHALL never be asserted in the same cycle.

Reset
REQ-030 While reset=1 the block SHALL hold state HOLD with div_resetn=0, div_calib=0, ready=0, busy=1, slip_ack=0 and all counters 0.
REQ-031 The RST_HOLD count SHALL begin on the first hclkin rising edge after reset deasserts.

Configuration
REQ-032 With macro CLKDIV_SEQ_SLIPCNT_EN defined, the block SHALL have port slip_total, output, 8 bits.
REQ-033 With the macro defined, slip_total SHALL increment once per div_calib rising edge, wrap 255->0, and clear only on reset, not on restart.
REQ-034 Without CLKDIV_SEQ_SLIPCNT_EN the slip_total port and its counter SHALL be absent; all other behaviour SHALL be identical.

Verification
REQ-035 The bench SHALL check defaults with reset released at edge 0 -> div_resetn low through edge 16 and high after it, ready=1 after edge 80, busy the complement of ready.
REQ-036 The bench SHALL check slip_num=3 accepted in READY -> three 2-cycle div_calib pulses separated by 8 low cycles, ready=0 for 30 cycles, then one slip_ack pulse and ready=1.
REQ-037 The bench SHALL check slip_num=0 in READY -> slip_ack next cycle, no div_calib activity, ready stays 1.
REQ-038 The bench SHALL check restart asserted during the second cycle of a CAL_HI pulse -> div_calib=0 and div_resetn=0 next cycle, 16 low cycles, no slip_ack, ready after 80 more cycles.
REQ-039 The bench SHALL check slip_req=1 with slip_num=2 held from reset through SETTLE -> no pulse before ready rises, then 2 pulses and ack; slip_req must drop on ack and no re-acceptance may occur.
REQ-040 The bench SHALL check, with CLKDIV_SEQ_SLIPCNT_EN, requests of 3 then 3 -> slip_total=6, unchanged by restart, and 0 after 256 total slips.
